// File: rtl/iot_monitor_pkg.sv
// Shared types and helpers for the multi-channel IoT active-device monitor.
// Optional feature macro used by the monitor: IOT_MONITOR_PEAK_HOLD_EN.
//   alarm_state_t : hysteresis alarm FSM states
//   SUM_W         : width of a per-cycle channel popcount (up to 16 channels)
//   popcount()    : number of set bits in a 16-bit channel mask
package iot_monitor_pkg;

   typedef enum logic {A_IDLE, A_HIGH} alarm_state_t;

   localparam int SUM_W = 5;

   function automatic logic [SUM_W-1:0] popcount(input logic [15:0] v);
      logic [SUM_W-1:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + SUM_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/iot_monitor_if.sv
// Device-event bus between the event front end and the monitor.
//   change  : per-channel event strobe (front end -> monitor)
//   on_off  : per-channel direction, 1 = on, 0 = off (front end -> monitor)
//   state   : alarm FSM state, exposed for observation (monitor -> front end)
// Handshake: change[i] is a single-cycle strobe qualified by itself; there is
// no ready/backpressure, the monitor accepts every strobe on the edge it is
// sampled, and on_off[i] is only meaningful while change[i] is high.
interface iot_monitor_if #(
   parameter int N_CH = 4
);
   import iot_monitor_pkg::*;

   logic [N_CH-1:0] change;
   logic [N_CH-1:0] on_off;
   alarm_state_t    state;

   modport master (output change, output on_off, input  state);
   modport slave  (input  change, input  on_off, output state);
endinterface

// File: rtl/iot_alarm_fsm.sv
// Hysteresis alarm for the active-device count.
// Sets when the upcoming count reaches HI_THR, clears when it falls to LO_THR.
//   clk, rst : clock, asynchronous active-high reset
//   next     : count value being loaded into the counter this cycle
//   state    : current FSM state (observable)
//   alarm    : high while in A_HIGH
module iot_alarm_fsm
   import iot_monitor_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int HI_THR = 200,
   parameter int LO_THR = 150
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] next,
   output alarm_state_t     state,
   output logic             alarm
);

   alarm_state_t state_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= A_IDLE;
      else     state <= state_nx;
   end

   // Working from the counter's next value keeps alarm aligned with counter_out.
   always_comb begin
      state_nx = state;
      case (state)
         A_IDLE:  if (next >= WIDTH'(HI_THR)) state_nx = A_HIGH;
         A_HIGH:  if (next <= WIDTH'(LO_THR)) state_nx = A_IDLE;
         default: state_nx = A_IDLE;
      endcase
   end

   assign alarm = (state == A_HIGH);

endmodule

// File: rtl/iot_monitor_mc.sv
// Multi-channel active IoT device counter with saturation and hysteresis alarm.
// Merges up to N_CH on/off events per clock into one saturating count.
// Optional peak-hold register: define IOT_MONITOR_PEAK_HOLD_EN.
//   clk, rst    : clock, asynchronous active-high reset
//   clr         : synchronous clear of count, alarm, sat_err and peak
//   ev          : event bus (change/on_off in, alarm FSM state out)
//   counter_out : active-device count
//   at_max      : counter_out == MAX_COUNT
//   at_zero     : counter_out == 0
//   alarm       : hysteresis alarm
//   sat_err     : sticky, a clamp at 0 or MAX_COUNT has happened
//   peak_out    : highest count seen since reset/clear (0 when feature off)
module iot_monitor_mc
   import iot_monitor_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int N_CH      = 4,
   parameter int MAX_COUNT = 255,
   parameter int HI_THR    = 200,
   parameter int LO_THR    = 150
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   iot_monitor_if.slave     ev,
   output logic [WIDTH-1:0] counter_out,
   output logic             at_max,
   output logic             at_zero,
   output logic             alarm,
   output logic             sat_err,
   output logic [WIDTH-1:0] peak_out
);

   // Two guard bits above the count plus room for N_CH events: the sum can
   // never wrap, and a negative result shows up in the top bit.
   localparam int RAW_W = WIDTH + $clog2(N_CH) + 2;

   logic [SUM_W-1:0] up;
   logic [SUM_W-1:0] dn;
   logic [RAW_W-1:0] raw;
   logic [WIDTH-1:0] next;
   logic             clamp;

   always_comb begin
      up    = popcount(16'(ev.change & ev.on_off));
      dn    = popcount(16'(ev.change & ~ev.on_off));
      // Ups and downs net out before the clamp is applied.
      raw   = RAW_W'(counter_out) + RAW_W'(up) - RAW_W'(dn);
      next  = raw[WIDTH-1:0];
      clamp = 1'b0;
      if (raw[RAW_W-1]) begin
         next  = '0;
         clamp = 1'b1;
      end else if (raw > RAW_W'(MAX_COUNT)) begin
         next  = WIDTH'(MAX_COUNT);
         clamp = 1'b1;
      end
      // Clear wins over any events in the same cycle.
      if (clr) begin
         next  = '0;
         clamp = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter_out <= '0;
         at_max      <= 1'b0;
         at_zero     <= 1'b1;
         sat_err     <= 1'b0;
      end else begin
         counter_out <= next;
         at_max      <= (next == WIDTH'(MAX_COUNT));
         at_zero     <= (next == '0);
         sat_err     <= clr ? 1'b0 : (sat_err | clamp);
      end
   end

   // clr forces next to 0, which is always <= LO_THR, so it also drops the alarm.
   iot_alarm_fsm #(
      .WIDTH  (WIDTH),
      .HI_THR (HI_THR),
      .LO_THR (LO_THR)
   ) u_alarm (
      .clk   (clk),
      .rst   (rst),
      .next  (next),
      .state (ev.state),
      .alarm (alarm)
   );

`ifdef IOT_MONITOR_PEAK_HOLD_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  peak_out <= '0;
      else if (clr)             peak_out <= '0;
      else if (next > peak_out) peak_out <= next;
   end
`else
   assign peak_out = '0;
`endif

endmodule

// File: tb/tb_iot_monitor_mc.sv
// Self-checking bench for iot_monitor_mc (default parameters, N_CH = 4).
module tb_iot_monitor_mc;
   import iot_monitor_pkg::*;

`ifdef IOT_MONITOR_PEAK_HOLD_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       clr;
   logic [7:0] counter_out;
   logic       at_max;
   logic       at_zero;
   logic       alarm;
   logic       sat_err;
   logic [7:0] peak_out;

   int total = 0;
   int bad   = 0;

   iot_monitor_if #(.N_CH(4)) ev ();

   iot_monitor_mc dut (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .ev          (ev),
      .counter_out (counter_out),
      .at_max      (at_max),
      .at_zero     (at_zero),
      .alarm       (alarm),
      .sat_err     (sat_err),
      .peak_out    (peak_out)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- vector table ----------------
   typedef struct {
      logic       clr;
      logic [3:0] change;
      logic [3:0] on_off;
      int         cnt;
      logic       at_max;
      logic       at_zero;
      logic       alarm;
      logic       sat;
      int         peak;
   } vec_t;

   vec_t vecs[11];

   // ---------------- driver / checker tasks ----------------
   task automatic step(input logic c, input logic [3:0] ch, input logic [3:0] oo);
      @(negedge clk);
      clr       = c;
      ev.change = ch;
      ev.on_off = oo;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int cnt, input logic mx,
                            input logic zr, input logic al, input logic st,
                            input int pk);
      check({tag, ".counter_out"}, int'(counter_out), cnt);
      check({tag, ".at_max"},      int'(at_max),      int'(mx));
      check({tag, ".at_zero"},     int'(at_zero),     int'(zr));
      check({tag, ".alarm"},       int'(alarm),       int'(al));
      check({tag, ".sat_err"},     int'(sat_err),     int'(st));
      check({tag, ".peak_out"},    int'(peak_out),    PEAK_EN ? pk : 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      //          clr change  on_off  cnt max zr al st peak
      vecs[0]  = '{1'b0, 4'b1111, 4'b1011, 2, 0, 0, 0, 0, 2};  // +3 -1
      vecs[1]  = '{1'b0, 4'b0011, 4'b0000, 0, 0, 1, 0, 0, 2};  // -2
      vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 0, 0, 1, 0, 1, 2};  // underflow clamp
      vecs[3]  = '{1'b0, 4'b0000, 4'b1111, 0, 0, 1, 0, 1, 2};  // on_off ignored
      vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 0, 0, 1, 0, 0, 0};  // clr drops sat_err
      vecs[5]  = '{1'b0, 4'b0011, 4'b0010, 0, 0, 1, 0, 0, 0};  // +1 -1 at zero
      vecs[6]  = '{1'b0, 4'b0101, 4'b0101, 2, 0, 0, 0, 0, 2};  // +2
      vecs[7]  = '{1'b0, 4'b1010, 4'b0000, 0, 0, 1, 0, 0, 2};  // -2
      vecs[8]  = '{1'b0, 4'b1000, 4'b1000, 1, 0, 0, 0, 0, 2};  // +1
      vecs[9]  = '{1'b0, 4'b0110, 4'b0000, 0, 0, 1, 0, 1, 2};  // 1-2 clamps
      vecs[10] = '{1'b1, 4'b1111, 4'b1111, 0, 0, 1, 0, 0, 0};  // clr beats ups

      rst = 1'b1; clr = 1'b0; ev.change = '0; ev.on_off = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all("reset", 0, 0, 1, 0, 0, 0);
      check("reset.state", int'(ev.state), int'(A_IDLE));

      for (int i = 0; i < 11; i++) begin
         step(vecs[i].clr, vecs[i].change, vecs[i].on_off);
         check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].at_max,
                   vecs[i].at_zero, vecs[i].alarm, vecs[i].sat, vecs[i].peak);
      end

      // Overflow: 4 ups per cycle from 0.
      for (int i = 0; i < 63; i++) step(1'b0, 4'hf, 4'hf);
      check_all("ovf63", 252, 0, 0, 1, 0, 252);
      step(1'b0, 4'hf, 4'hf);
      check_all("ovf64", 255, 1, 0, 1, 1, 255);
      step(1'b0, 4'hf, 4'hf);
      check_all("ovf65", 255, 1, 0, 1, 1, 255);
      check("ovf.state", int'(ev.state), int'(A_HIGH));

      // Hysteresis.
      step(1'b1, 4'h0, 4'h0);
      check_all("hys_clr", 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 49; i++) step(1'b0, 4'hf, 4'hf);
      check_all("hys196", 196, 0, 0, 0, 0, 196);
      step(1'b0, 4'hf, 4'hf);
      check_all("hys200", 200, 0, 0, 1, 0, 200);
      for (int i = 0; i < 12; i++) step(1'b0, 4'hf, 4'h0);
      check_all("hys152", 152, 0, 0, 1, 0, 200);
      step(1'b0, 4'b0001, 4'b0000);
      check_all("hys151", 151, 0, 0, 1, 0, 200);
      step(1'b0, 4'b0001, 4'b0000);
      check_all("hys150", 150, 0, 0, 0, 0, 200);
      step(1'b0, 4'b0100, 4'b0100);
      check_all("hys151up", 151, 0, 0, 0, 0, 200);

      // Peak hold and clr priority.
      step(1'b1, 4'h0, 4'h0);
      for (int i = 0; i < 10; i++) step(1'b0, 4'hf, 4'hf);
      check_all("pk40", 40, 0, 0, 0, 0, 40);
      for (int i = 0; i < 7; i++) step(1'b0, 4'hf, 4'h0);
      step(1'b0, 4'b0011, 4'b0000);
      check_all("pk10", 10, 0, 0, 0, 0, 40);
      step(1'b1, 4'hf, 4'hf);
      check_all("pk_clr", 0, 0, 1, 0, 0, 0);

      // Asynchronous reset mid-operation, with events pending.
      step(1'b0, 4'hf, 4'hf);
      step(1'b0, 4'hf, 4'hf);
      check_all("pre_rst", 8, 0, 0, 0, 0, 8);
      @(negedge clk);
      ev.change = 4'hf; ev.on_off = 4'hf;
      #2 rst = 1'b1;
      #1;
      check_all("async_rst", 0, 0, 1, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all("rst_hold", 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_all("post_rst", 4, 0, 0, 0, 0, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
